// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential add-shift multiplier controller.
//   mult_state_t : controller state encoding (TEST is a reserved code that the
//                  FSM never enters; the add/shift decision is folded into the
//                  transitions out of CLRA and SHIFT instead).
//   cnt_w()      : width of the iteration counter for a given operand width,
//                  wide enough to hold the value WIDTH itself.
// ---------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLRA  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    HOLD  = 3'd5
  } mult_state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_iter_counter.sv
// ---------------------------------------------------------------------------
// mult_iter_counter
// Counts completed shift iterations of one multiplication run.
// Ports:
//   Clk      : system clock, rising edge
//   Reset    : asynchronous, active-high; count returns to 0
//   clr_i    : synchronous clear (takes priority over en_i)
//   en_i     : increment by one this cycle
//   count_o  : current iteration count, 0..WIDTH
//   last_o   : count_o == WIDTH-1, i.e. the iteration in progress is the
//              final one (the sign-bit iteration in two's-complement mode)
// ---------------------------------------------------------------------------
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      clr_i,
  input  logic                      en_i,
  output logic [cnt_w(WIDTH)-1:0]   count_o,
  output logic                      last_o
);

  localparam int CW = cnt_w(WIDTH);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins over increment so a new run always starts at 0.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mult_seq_ctrl
// Control unit for a sequential add-shift multiplier datapath (X:A:B shift
// chain plus a (WIDTH+1)-bit adder/subtractor). Runs WIDTH add/shift
// iterations using an iteration counter, in signed or unsigned mode.
// Ports:
//   Clk, Reset    : clock (rising edge), asynchronous active-high reset
//   Run           : start request, acted on at its rising edge
//   ClearA_LoadB  : request to clear A/X and load B (only honoured when idle
//                   or holding a result)
//   M             : multiplier bit currently presented by the datapath
//   Signed        : 1 = two's complement, 0 = unsigned; latched at start
//   Shift_En      : shift X:A:B right this cycle
//   Add / Sub     : load A <- A + S / A <- A - S this cycle
//   Clr_Ld        : gated ClearA_LoadB
//   Clr_A         : clear A and X (first cycle of every run)
//   Busy / Done   : run in progress / result valid in X:A:B
//   Count         : shifts completed in the current run
// ---------------------------------------------------------------------------
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Run,
  input  logic                      ClearA_LoadB,
  input  logic                      M,
  input  logic                      Signed,
  output logic                      Shift_En,
  output logic                      Add,
  output logic                      Sub,
  output logic                      Clr_Ld,
  output logic                      Clr_A,
  output logic                      Busy,
  output logic                      Done,
  output logic [cnt_w(WIDTH)-1:0]   Count
);

  mult_state_t state_q;
  mult_state_t state_d;
  logic        runDly_q;
  logic        mode_q;
  logic        mode_d;
  logic        start;
  logic        cntClr;
  logic        cntEn;
  logic        cntLast;
  logic        subIter;

  // Run delay resets to 1 so that a Run level already high when reset is
  // released does not look like a rising edge.
  assign start = Run & ~runDly_q;

  // Counter is cleared when a run is accepted and advances once per shift.
  assign cntClr = (state_q == IDLE) && start;
  assign cntEn  = (state_q == SHIFT);

  mult_iter_counter #(
    .WIDTH (WIDTH)
  ) uCounter (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr_i   (cntClr),
    .en_i    (cntEn),
    .count_o (Count),
    .last_o  (cntLast)
  );

  // Next-state logic. The multiplier-bit test happens on the way out of
  // CLRA and SHIFT, so no cycle is spent in TEST. Leaving SHIFT on the last
  // iteration goes straight to HOLD regardless of M. TEST is unreachable and
  // recovers to IDLE should it ever be decoded.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = Signed;
          state_d = CLRA;
        end
      end
      CLRA: begin
        state_d = M ? ADD : SHIFT;
      end
      ADD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cntLast) begin
          state_d = HOLD;
        end else begin
          state_d = M ? ADD : SHIFT;
        end
      end
      HOLD: begin
        if (!Run) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched mode and Run history registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      runDly_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      runDly_q <= Run;
    end
  end

  // In two's-complement mode the final partial product carries negative
  // weight, so the ADD cycle of the last iteration subtracts instead.
  assign subIter = mode_q & cntLast;

  // Moore output decode; only Clr_Ld passes the live request through.
  always_comb begin
    Shift_En = (state_q == SHIFT);
    Add      = (state_q == ADD) & ~subIter;
    Sub      = (state_q == ADD) &  subIter;
    Clr_A    = (state_q == CLRA);
    Busy     = (state_q == CLRA) | (state_q == ADD) | (state_q == SHIFT);
    Done     = (state_q == HOLD);
    Clr_Ld   = ClearA_LoadB & ((state_q == IDLE) | (state_q == HOLD));
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mult_seq_ctrl
// Self-checking bench for mult_seq_ctrl (WIDTH = 8) driving a behavioural
// model of the X:A:B datapath. Expected results of each run are queued when
// the run is started and compared when Done rises.
// ---------------------------------------------------------------------------
module tb_mult_seq_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic [15:0] prod;
    int          shifts;
    int          adds;
    int          subs;
    int          lat;
  } exp_t;

  logic       Clk;
  logic       Reset;
  logic       Run;
  logic       ClearA_LoadB;
  logic       M;
  logic       Signed;
  logic       Shift_En;
  logic       Add;
  logic       Sub;
  logic       Clr_Ld;
  logic       Clr_A;
  logic       Busy;
  logic       Done;
  logic [3:0] Count;

  logic [7:0] swS;
  logic [7:0] swB;
  logic       dpSigned;
  logic       dpX;
  logic [7:0] dpA;
  logic [7:0] dpB;

  exp_t sbq[$];
  int   checkCount;
  int   failCount;

  mult_seq_ctrl #(
    .WIDTH (WIDTH)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Signed       (Signed),
    .Shift_En     (Shift_En),
    .Add          (Add),
    .Sub          (Sub),
    .Clr_Ld       (Clr_Ld),
    .Clr_A        (Clr_A),
    .Busy         (Busy),
    .Done         (Done),
    .Count        (Count)
  );

  // Free-running 10 ns clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // The controller decides on leaving SHIFT, so during a shift cycle the
  // datapath presents the bit that will be the LSB after the shift.
  assign M = Shift_En ? dpB[1] : dpB[0];

  // Behavioural datapath: X:A:B shift chain with a 9-bit adder/subtractor.
  // Unsigned mode keeps the carry in X for one shift, then clears it.
  always @(posedge Clk) begin
    if (Clr_Ld) begin
      dpA <= 8'h00;
      dpX <= 1'b0;
      dpB <= swB;
    end else if (Clr_A) begin
      dpA <= 8'h00;
      dpX <= 1'b0;
    end else if (Add) begin
      if (dpSigned) {dpX, dpA} <= {dpA[7], dpA} + {swS[7], swS};
      else          {dpX, dpA} <= {1'b0, dpA} + {1'b0, swS};
    end else if (Sub) begin
      {dpX, dpA} <= {dpA[7], dpA} - {swS[7], swS};
    end else if (Shift_En) begin
      dpX <= dpSigned ? dpX : 1'b0;
      dpA <= {dpX, dpA[7:1]};
      dpB <= {dpA[0], dpB[7:1]};
    end
  end

  function automatic int popcnt(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One complete multiplication: load B, start, watch every cycle until Done
  // (bounded), then compare against the queued expectation and exit HOLD.
  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] b,
                               input logic sgn, input bit flipSigned);
    exp_t e;
    int   si, bi, cyc, nShift, nAdd, nSub, nExcl;
    bit   gotDone;
    logic clrLdMid;

    @(negedge Clk);
    swS = s;
    swB = b;
    ClearA_LoadB = 1'b1;
    #1;
    checkOutput("clrld_idle", 32'(Clr_Ld), 32'd1);
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    Signed   = sgn;
    dpSigned = sgn;

    if (sgn) begin
      si = $signed(s);
      bi = $signed(b);
      e.adds = popcnt(b & 8'h7F);
      e.subs = int'(b[7]);
    end else begin
      si = int'(s);
      bi = int'(b);
      e.adds = popcnt(b);
      e.subs = 0;
    end
    e.prod   = 16'(si * bi);
    e.shifts = WIDTH;
    e.lat    = 2 + WIDTH + popcnt(b);
    sbq.push_back(e);

    Run = 1'b1;
    cyc = 0; nShift = 0; nAdd = 0; nSub = 0; nExcl = 0;
    gotDone = 1'b0;
    clrLdMid = 1'b0;
    while (cyc < 100 && !gotDone) begin
      @(posedge Clk);
      @(negedge Clk);
      cyc++;
      if (cyc == 1)
        checkOutput("clra_first", 32'({Clr_A, Busy, Add, Sub, Shift_En}),
                    32'b11000);
      nShift += int'(Shift_En);
      nAdd   += int'(Add);
      nSub   += int'(Sub);
      if (int'(Shift_En) + int'(Add) + int'(Sub) + int'(Clr_A) > 1) nExcl++;
      if (cyc == 2 && flipSigned) Signed = ~sgn;
      if (cyc == 3) begin
        ClearA_LoadB = 1'b1;
        #1;
        clrLdMid = Clr_Ld;
        ClearA_LoadB = 1'b0;
      end
      if (Done) gotDone = 1'b1;
    end
    checkOutput("done_seen", 32'(gotDone), 32'd1);

    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput("latency",   32'(cyc),    32'(e.lat));
      checkOutput("shifts",    32'(nShift), 32'(e.shifts));
      checkOutput("adds",      32'(nAdd),   32'(e.adds));
      checkOutput("subs",      32'(nSub),   32'(e.subs));
      checkOutput("product",   32'({dpA, dpB}), 32'(e.prod));
    end
    checkOutput("exclusive",   32'(nExcl),    32'd0);
    checkOutput("clrld_busy",  32'(clrLdMid), 32'd0);
    checkOutput("count_hold",  32'(Count),    32'(WIDTH));
    checkOutput("busy_hold",   32'(Busy),     32'd0);

    ClearA_LoadB = 1'b1;
    #1;
    checkOutput("clrld_hold", 32'(Clr_Ld), 32'd1);
    ClearA_LoadB = 1'b0;

    Run = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    checkOutput("idle_after", 32'({Done, Busy}), 32'd0);
  endtask

  // Top-level sequence: reset behaviour, directed runs, mid-run abort and a
  // few random operands.
  initial begin
    bit found;
    checkCount = 0;
    failCount  = 0;
    Reset = 1'b1;
    Run = 1'b1;
    ClearA_LoadB = 1'b1;
    Signed = 1'b0;
    swS = 8'h00;
    swB = 8'h00;
    dpSigned = 1'b0;

    #12;
    checkOutput("clrld_reset", 32'(Clr_Ld), 32'd1);
    ClearA_LoadB = 1'b0;
    #1;
    checkOutput("outs_reset",
                32'({Shift_En, Add, Sub, Clr_A, Busy, Done, Clr_Ld}), 32'd0);
    checkOutput("count_reset", 32'(Count), 32'd0);

    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    checkOutput("run_held_idle", 32'({Busy, Done, Clr_A}), 32'd0);
    Run = 1'b0;

    applyStimulus(8'h5A, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge Clk);
    checkOutput("single_run", 32'({Busy, Done}), 32'd0);

    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1);
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0);

    // Abort a run with Reset in the ADD cycle at Count=3.
    @(negedge Clk);
    swS = 8'h03;
    swB = 8'hFF;
    ClearA_LoadB = 1'b1;
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    Signed = 1'b0;
    dpSigned = 1'b0;
    Run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge Clk);
      if (Add && Count == 4'd3) found = 1'b1;
    end
    checkOutput("reach_add3", 32'(found), 32'd1);
    Reset = 1'b1;
    #1;
    checkOutput("outs_abort",
                32'({Shift_En, Add, Sub, Clr_A, Busy, Done}), 32'd0);
    checkOutput("count_abort", 32'(Count), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("run_held_abort", 32'({Busy, Done}), 32'd0);
    Run = 1'b0;
    applyStimulus(8'h81, 8'hA5, 1'b1, 1'b0);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'(k % 2), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Parametrised control unit for the sequential add-shift multiplier datapath (A/B shift registers, X sign flip-flop, (WIDTH+1)-bit adder/subtractor). It sequences WIDTH add/shift iterations with a counter instead of unrolled states, and supports signed (two's-complement, subtract on MSB) and unsigned modes. It adds busy/done status and start-edge detection. It sits between the switch/button synchronisers and the datapath registers.

## Interface
- WIDTH, 8, multiplier operand width (2..32); sets iteration count.
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- Run  in  1  synchronised start request; level signal, acted on at its rising edge.
- ClearA_LoadB  in  1  synchronised request to clear A/X and load B from switches.
- M  in  1  current LSB of B (multiplier bit under test).
- Signed  in  1  1 = two's-complement mode, 0 = unsigned; sampled at start.
- Shift_En  out  1  shift X:A:B right by one this cycle.
- Add  out  1  load A ← A + S this cycle (X ← adder sign/carry).
- Sub  out  1  load A ← A − S this cycle.
- Clr_Ld  out  1  clear A/X and load B (gated ClearA_LoadB).
- Clr_A  out  1  clear A and X only (start of each run).
- Busy  out  1  multiplication in progress.
- Done  out  1  result valid in X:A:B.
- Count  out  $clog2(WIDTH+1)  shifts completed in the current run.

## Operation
- States (shared enum): IDLE, CLRA, TEST, ADD, SHIFT, HOLD.
- Start detect: register Run_d, reset value 1; start = Run & ~Run_d. Run held high through Reset does not start a run.
- IDLE: on start, latch Signed into mode_r, clear Count, go to CLRA.
- CLRA: Clr_A=1 for one cycle, then TEST.
- TEST: zero-output decision cycle, omitted. The decision is made combinationally when leaving CLRA or SHIFT:
  - M=1 and Count<WIDTH−1: go to ADD.
  - M=1, Count=WIDTH−1 and mode_r=1: go to ADD with Sub asserted instead of Add.
  - M=1, Count=WIDTH−1 and mode_r=0: go to ADD with Add asserted.
  - M=0: go to SHIFT.
  - TEST is retained in the enum as a reserved encoding only.
- ADD: exactly one of Add/Sub=1 for one cycle, then SHIFT.
- SHIFT: Shift_En=1, Count increments. If the new Count=WIDTH, go to HOLD; otherwise take the decision above.
- HOLD: Done=1. Go to IDLE when Run=0. A fresh rising edge is required to start again.
- Clr_Ld = ClearA_LoadB only in IDLE or HOLD; forced 0 while Busy.
- Busy = 1 in CLRA, ADD, SHIFT.
- Add, Sub, Shift_En, Clr_A are mutually exclusive; at most one is high per cycle.

## Timing
- Reset (async): state IDLE, Count=0, Run_d=1, mode_r=0. All outputs 0 except Clr_Ld, which follows ClearA_LoadB.
- Latency from the first cycle Run=1 (edge) to Done=1: 1 (CLRA) + WIDTH (shifts) + popcount(B) (adds) + 1 cycles.
- Outputs are Moore (decoded from state and mode_r/Count registers), except Clr_Ld.
- Reset mid-run aborts immediately to IDLE. The datapath contents are then undefined.
- Run dropping mid-run is ignored; the run completes and HOLD exits on the next cycle.
- Signed is sampled only at the start; changes mid-run have no effect.
- The M=1 decision at Count=WIDTH−1 uses mode_r, not the live Signed input.

## Structure
- Package mult_pkg: state enum typedef mult_state_t, function cnt_w(WIDTH) returning $clog2(WIDTH+1).
- Sub-module mult_iter_counter:
  - Count register with clear, enable and a last flag (Count==WIDTH−1).
  - Parametrised by WIDTH.
- Top module holds the FSM, start-edge detector, mode_r and output decode.

## Test plan
- WIDTH=8, B=0x00, unsigned:
  - 8 Shift_En pulses and no Add/Sub.
  - Done at cycle 10 after the Run edge.
  - Count=8 in HOLD.
- WIDTH=8, B=0xFF, Signed=1:
  - 7 Add pulses, then 1 Sub on the 8th iteration.
  - Done after 18 cycles.
  - Datapath −1×−1 gives 0x0001.
- Same B=0xFF, Signed=0: 8 Add pulses and no Sub. 255×255 gives 0xFE01.
- Run held high across Reset release: FSM stays in IDLE. Lower then raise Run and exactly one run executes.
- ClearA_LoadB pulsed during a run: Clr_Ld stays 0. Pulsed in HOLD: Clr_Ld=1 in the same cycle.
- Reset asserted at Count=3 mid-ADD: all outputs 0 at once, state IDLE. The next Run edge restarts with CLRA.
